// File: rtl/fft_pkg.sv
// Shared constants and FSM state type for the radix-2 FFT sequencer.
package fft_pkg;

   localparam int unsigned LOG2_NMIN = 6;
   localparam int unsigned LOG2_NMAX = 10;
   localparam int unsigned MODE_MAX  = 4;
   localparam int unsigned TW_FRAC   = 14;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

endpackage

// File: rtl/fft_wr_delay.sv
// Fixed-depth shift register carrying {valid, addr_a, addr_b}; async reset flushes it.
module fft_wr_delay
   import fft_pkg::*;
#(
   parameter int unsigned DEPTH = 1,
   parameter int unsigned AW    = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          valid_in,
   input  logic [AW-1:0] addr_a_in,
   input  logic [AW-1:0] addr_b_in,
   output logic          valid_out,
   output logic [AW-1:0] addr_a_out,
   output logic [AW-1:0] addr_b_out
);

   localparam int unsigned W = 2 * AW + 1;

   logic [W-1:0] pipe [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= {valid_in, addr_a_in, addr_b_in};
         for (int unsigned i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign {valid_out, addr_a_out, addr_b_out} = pipe[DEPTH-1];

endmodule

// File: rtl/fft_stage_ctrl.sv
// Stage/butterfly/twiddle sequencer for the in-place radix-2 DIT FFT.
// Optional macro FFT_CTRL_SCALE_EN: request divide-by-2 on every butterfly.
module fft_stage_ctrl
   import fft_pkg::*;
#(
   parameter int unsigned LOG2_NMAX = fft_pkg::LOG2_NMAX,
   parameter int unsigned RD_LAT    = 1,
   parameter int unsigned BFY_LAT   = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [2:0]           mode,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [3:0]           stage,
   output logic                 rd_en,
   output logic [LOG2_NMAX-1:0] rd_addr_a,
   output logic [LOG2_NMAX-1:0] rd_addr_b,
   output logic [LOG2_NMAX-2:0] tw_addr,
   output logic                 bf_en,
   output logic                 wr_en,
   output logic [LOG2_NMAX-1:0] wr_addr_a,
   output logic [LOG2_NMAX-1:0] wr_addr_b,
   output logic                 scale
);

   localparam int unsigned AW       = LOG2_NMAX;
   localparam int unsigned KW       = LOG2_NMAX - 1;
   localparam int unsigned PIPE_LAT = RD_LAT + BFY_LAT;
   localparam int unsigned DW       = $clog2(PIPE_LAT + 1);

   state_t        state, state_nx;
   logic [KW-1:0] k, k_nx, k_last, tw_nx;
   logic [3:0]    s, s_nx, log2n;
   logic [DW-1:0] d, d_nx;
   logic [AW-1:0] span, a_nx;
   logic          mode_ok;
   logic [AW-1:0] unused_bf_addr_a, unused_bf_addr_b;

   assign mode_ok = (mode <= 3'(MODE_MAX));
   assign k_last  = (KW'(1) << (log2n - 4'd1)) - 1'b1;

   always_comb begin
      state_nx = state;
      k_nx     = k;
      s_nx     = s;
      d_nx     = '0;
      case (state)
         IDLE: if (start && mode_ok) begin
            state_nx = RUN;
            k_nx     = '0;
            s_nx     = '0;
         end
         RUN: if (k == k_last) begin
            state_nx = DRAIN;
            k_nx     = '0;
         end else begin
            k_nx = k + 1'b1;
         end
         DRAIN: if (d == DW'(PIPE_LAT - 1)) begin
            if (s == log2n - 4'd1) begin
               state_nx = DONE;
            end else begin
               state_nx = RUN;
               s_nx     = s + 4'd1;
            end
         end else begin
            d_nx = d + 1'b1;
         end
         DONE: begin
            state_nx = IDLE;
            s_nx     = '0;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Addresses are computed from the next counter values so they register alongside rd_en.
   assign span  = AW'(1) << s_nx;
   assign a_nx  = (({1'b0, k_nx} >> s_nx) << (s_nx + 4'd1)) | ({1'b0, k_nx} & (span - 1'b1));
   assign tw_nx = (k_nx & KW'(span - 1'b1)) << (4'(KW) - s_nx);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         k         <= '0;
         s         <= '0;
         d         <= '0;
         log2n     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         rd_en     <= 1'b0;
         rd_addr_a <= '0;
         rd_addr_b <= '0;
         tw_addr   <= '0;
      end else begin
         state <= state_nx;
         k     <= k_nx;
         s     <= s_nx;
         d     <= d_nx;
         if (state == IDLE && start && mode_ok) log2n <= 4'(LOG2_NMIN) + {1'b0, mode};
         busy      <= (state_nx != IDLE);
         done      <= (state_nx == DONE);
         err       <= (state == IDLE) && start && !mode_ok;
         rd_en     <= (state_nx == RUN);
         rd_addr_a <= (state_nx == RUN) ? a_nx : '0;
         rd_addr_b <= (state_nx == RUN) ? (a_nx | span) : '0;
         tw_addr   <= (state_nx == RUN) ? tw_nx : '0;
      end
   end

   assign stage = s;

   fft_wr_delay #(.DEPTH(RD_LAT), .AW(AW)) u_bf_dly (
      .clk        (clk),
      .rst_n      (rst_n),
      .valid_in   (rd_en),
      .addr_a_in  (rd_addr_a),
      .addr_b_in  (rd_addr_b),
      .valid_out  (bf_en),
      .addr_a_out (unused_bf_addr_a),
      .addr_b_out (unused_bf_addr_b)
   );

   fft_wr_delay #(.DEPTH(PIPE_LAT), .AW(AW)) u_wr_dly (
      .clk        (clk),
      .rst_n      (rst_n),
      .valid_in   (rd_en),
      .addr_a_in  (rd_addr_a),
      .addr_b_in  (rd_addr_b),
      .valid_out  (wr_en),
      .addr_a_out (wr_addr_a),
      .addr_b_out (wr_addr_b)
   );

`ifdef FFT_CTRL_SCALE_EN
   assign scale = bf_en;
`else
   assign scale = 1'b0;
`endif

endmodule

// File: doc/fft_stage_ctrl.md
# fft_stage_ctrl

Sequencer for the in-place radix-2 DIT FFT engine. It walks the stage, butterfly and twiddle indices for a run-time selected transform size (64…1024 points). It drives the dual-port sample RAM read/write addresses, the twiddle ROM address, and the butterfly enable, and it aligns write-back with the RAM read latency and the butterfly latency. A start/busy/done handshake connects it to the top-level FFT controller.

## Interface
- `LOG2_NMAX`, 10: log2 of largest transform; sets RAM address width.
- `RD_LAT`, 1: sample RAM/twiddle ROM read latency, cycles.
- `BFY_LAT`, 1: butterfly input-to-output latency, cycles.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request; honoured only in IDLE.
- `mode`  in  3  size select: N = 2^(6+mode); 0..4 valid; sampled with `start`.
- `busy`  out  1  high from the cycle after accepted `start` through the `done` cycle.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse when `start` arrives with mode > 4 in IDLE.
- `stage`  out  4  current stage index s.
- `rd_en`  out  1  read strobe to RAM and twiddle ROM.
- `rd_addr_a`, `rd_addr_b`  out  LOG2_NMAX  butterfly operand addresses.
- `tw_addr`  out  LOG2_NMAX-1  twiddle ROM index (table sized for NMAX, Q1.14).
- `bf_en`  out  1  butterfly enable; equals `rd_en` delayed RD_LAT.
- `wr_en`  out  1  write strobe; equals `rd_en` delayed RD_LAT+BFY_LAT.
- `wr_addr_a`, `wr_addr_b`  out  LOG2_NMAX  `rd_addr_*` delayed RD_LAT+BFY_LAT.
- `scale`  out  1  per-stage divide-by-2 request to datapath (see Configuration).

## Operation
- FSM: IDLE → RUN (start accepted, mode ≤ 4) → DRAIN (last butterfly of stage issued) → RUN (s < log2N-1) or DONE → IDLE.
- Invalid mode: the block stays in IDLE, pulses `err`, and `busy` stays 0.
- RUN: one butterfly per cycle, with k = 0 … N/2-1 and `rd_en` = 1.
- Addressing for stage s, span = 2^s:
  - `rd_addr_a` = ((k>>s)<<(s+1)) | (k & (span-1)).
  - `rd_addr_b` = `rd_addr_a` | span.
  - `tw_addr` = (k & (span-1)) << (LOG2_NMAX-1-s).
  - Upper address bits above log2N are always 0.
- Input data is in bit-reversed order (the loader's job). Output is in natural order.
- DRAIN: `rd_en` = 0 for exactly RD_LAT+BFY_LAT cycles. This guarantees the final writes of stage s land before stage s+1 reads (no RAW hazard). The delay pipe keeps shifting during DRAIN.
- DONE: pulses `done` one cycle, then returns to IDLE. The delay pipe is empty at that point.
- `start` in RUN/DRAIN/DONE is ignored. `mode` changes during a run are ignored.
- Reset mid-run: every state and output clears immediately. The delay pipe is flushed (`wr_en` = 0), so no partial write occurs after reset release.

## Timing
- Reset values: all outputs 0, FSM IDLE, k = 0, s = 0.
- Cycle 0: `start` sampled.
- Cycle 1: `busy` = 1, first `rd_en`.
- Stage length: N/2 + RD_LAT + BFY_LAT cycles.
- `done` in cycle log2N·(N/2+RD_LAT+BFY_LAT)+1. Default N=64: cycle 205. N=1024: cycle 5141.
- `busy` falls the cycle after `done`. A new `start` is accepted in that same cycle.
- `bf_en`, `wr_en` and write addresses are registered outputs. `rd_*` and `tw_addr` are registered from the counters.

## Configuration
- `FFT_CTRL_SCALE_EN` defined:
  - `scale` = 1 whenever `bf_en` = 1, so every stage halves. Total gain is 1/N and overflow is impossible.
- Not defined:
  - `scale` is tied to 0. The datapath runs unscaled and the caller limits input amplitude.

## Structure
- Shared package `fft_pkg` holds:
  - LOG2_NMIN = 6, LOG2_NMAX default, and MODE_MAX = 4.
  - FSM state enum (IDLE, RUN, DRAIN, DONE).
  - Q-format constant TW_FRAC = 14.
- Sub-module `fft_wr_delay`: parameterised-depth shift register carrying {valid, addr_a, addr_b}. It is instantiated twice: depth RD_LAT for `bf_en`, depth RD_LAT+BFY_LAT for the write side. Async reset clears it.

## Test plan
- Mode 0, start: `busy` at cycle 1, 192 `rd_en` cycles total, `done` at cycle 205; stage 0 k=3 → addresses (6,7), `tw_addr` 0.
- Mode 0, stage 2, k=5: `rd_addr_a`=9, `rd_addr_b`=13, `tw_addr`=1<<7=128; `wr_addr_a`=9 exactly 2 cycles later with `wr_en`=1.
- Stage boundary: last write of stage s occurs before first read of stage s+1; bench checks zero overlap of read/write addresses in the same cycle across the boundary for mode 4.
- `start` asserted at cycle 50 during a run → ignored, `done` still at 205. `start` with mode=5 in IDLE → `err` pulse, `busy` stays 0.
- Assert `rst_n`=0 at cycle 100 → all outputs 0 within the same cycle, no `wr_en` after release; restart with mode 4 → `done` at cycle 5141.
- With `FFT_CTRL_SCALE_EN`: `scale` equals `bf_en` every cycle. Without the macro: `scale` is constant 0.
